// File: rtl/full_adder_4bit_pkg.sv
// rtl/full_adder_4bit_pkg.sv - shared constants for the registered ripple adder
package full_adder_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder_4bit_if.sv
// rtl/full_adder_4bit_if.sv - operand/result bundle for the registered ripple adder
interface full_adder_4bit_if
  import full_adder_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin,
    input  out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output out_valid, S, Cout, Ovf
  );

endinterface

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - combinational 1-bit full-adder cell
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_4bit.sv
// rtl/full_adder_4bit.sv - registered ripple-carry adder with carry-out and signed overflow
module full_adder_4bit
  import full_adder_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  full_adder_4bit_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign carry[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_1bit u_cell (
      .a    (bus.A[i]),
      .b    (bus.B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Results only move on an accepted operand set; otherwise the last one is held.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d     = sum;
      cout_d  = carry[WIDTH];
      ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_4bit.sv
// tb/tb_full_adder_4bit.sv - scoreboard bench for the registered 4-bit adder
module tb_full_adder_4bit;

  logic clk = 1'b0;
  logic rst;

  full_adder_4bit_if #(.WIDTH(4)) bus ();

  full_adder_4bit #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] s, input logic co, input logic ov, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = c;
    e.s = s; e.cout = co; e.ovf = ov; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = a[0];
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("S[%0d]", e.tag), {28'd0, bus.S}, {28'd0, e.s});
        check($sformatf("Cout[%0d]", e.tag), {31'd0, bus.Cout}, {31'd0, e.cout});
        check($sformatf("Ovf[%0d]", e.tag), {31'd0, bus.Ovf}, {31'd0, e.ovf});
      end
    end
  end

  typedef struct {
    logic [3:0] a, b;
    logic       c;
    logic [3:0] s;
    logic       co, ov;
  } vec_t;

  vec_t dir[11] = '{
    '{4'b0010, 4'b0101, 1'b0, 4'b0111, 1'b0, 1'b0},
    '{4'b0000, 4'b0010, 1'b1, 4'b0011, 1'b0, 1'b0},
    '{4'b0000, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0},
    '{4'b0100, 4'b0001, 1'b1, 4'b0110, 1'b0, 1'b0},
    '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0},
    '{4'b0101, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0},
    '{4'b0101, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0},
    '{4'b0110, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b1},
    '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0},
    '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0},
    '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1}
  };

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 4'b1111;
    bus.B        = 4'b1111;
    bus.Cin      = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_S", {28'd0, bus.S}, 32'd0);
      check("rst_Cout", {31'd0, bus.Cout}, 32'd0);
      check("rst_Ovf", {31'd0, bus.Ovf}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    for (int i = 0; i < 11; i++)
      issue(dir[i].a, dir[i].b, dir[i].c, dir[i].s, dir[i].co, dir[i].ov, i);

    // Hold: last result 0111 must survive three idle cycles with changing operands.
    issue(4'b0010, 4'b0101, 1'b0, 4'b0111, 1'b0, 1'b0, 100);
    idle(4'b1001, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      idle(4'(i * 5 + 3), 4'(15 - i));
      @(negedge clk);
      check("hold_S", {28'd0, bus.S}, 32'h7);
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // Reset wins over a simultaneous valid operand set.
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 4'b0101;
    bus.B        = 4'b0101;
    bus.Cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstpri_S", {28'd0, bus.S}, 32'd0);
    check("rstpri_Cout", {31'd0, bus.Cout}, 32'd0);
    check("rstpri_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    for (int k = 0; k < 512; k++) begin
      logic [3:0] a, b;
      logic       c;
      int         u, sg;
      a  = 4'(k >> 5);
      b  = 4'(k >> 1);
      c  = k[0];
      u  = int'(a) + int'(b) + int'(c);
      sg = int'($signed(a)) + int'($signed(b)) + int'(c);
      issue(a, b, c, 4'(u), u >= 16, (sg > 7) || (sg < -8), 1000 + k);
    end
    idle(4'd0, 4'd0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++)
      @(posedge clk);
    @(negedge clk);
    check("drain_pending", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
